// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-ported byte-addressed memory between the fetch port (10-byte read)
// and the data port (8-byte read/write), with bounds checking and an ack timeout.
module dmem_port_arbiter #(
  parameter int unsigned MEM_SIZE     = 1024,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [79:0] if_rdata,
  output logic        if_done,
  output logic        imem_error,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_done,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_len,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [79:0] mem_rdata,
  input  logic        mem_ack,
  output logic        owner,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [63:0]   MEM_SIZE64 = 64'(MEM_SIZE);
  localparam logic [3:0]    LEN_FETCH  = 4'd10;
  localparam logic [3:0]    LEN_DATA   = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q;
  logic          we_q;
  logic [3:0]    len_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic          err_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] starve_q;
  logic [79:0]   if_rdata_q;
  logic [63:0]   dm_rdata_q;

  logic          grant_dm;
  logic          grant_if;
  logic [3:0]    grant_len;
  logic [63:0]   grant_addr;
  logic          grant_oob;
  logic          timer_done;

  // Data wins unless fetch has already been passed over STARVE_LIMIT times in a row.
  assign grant_dm   = dm_req && (!if_req || (starve_q < STARVE_MAX));
  assign grant_if   = !grant_dm && if_req;
  assign grant_len  = grant_dm ? LEN_DATA : LEN_FETCH;
  assign grant_addr = grant_dm ? dm_addr : if_addr;
  // Compare against MEM_SIZE-len so addr+len can never wrap past 2^64.
  assign grant_oob  = grant_addr > (MEM_SIZE64 - {60'd0, grant_len});
  assign timer_done = (timer_q == TIMER_LAST);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_dm || grant_if) state_d = grant_oob ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timer_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the read-data holding registers are reset too, because every output must be 0 in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_dm || grant_if) begin
            owner_q <= grant_dm;
            we_q    <= grant_dm && dm_we;
            len_q   <= grant_len;
            addr_q  <= grant_addr;
            wdata_q <= grant_dm ? dm_wdata : 64'd0;
            err_q   <= grant_oob;
            timer_q <= '0;
          end
          if (grant_dm && if_req)
            starve_q <= (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
          else
            starve_q <= '0;
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) begin
              if (owner_q) dm_rdata_q <= mem_rdata[63:0];
              else         if_rdata_q <= mem_rdata;
            end
          end else if (timer_done) begin
            err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = (state_q == ACCESS);
  assign mem_we     = mem_req && we_q;
  assign mem_len    = len_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);
  assign if_done    = (state_q == RESP) && !owner_q;
  assign dm_done    = (state_q == RESP) && owner_q;
  assign imem_error = if_done && err_q;
  assign dmem_error = dm_done && err_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a byte-array memory model with programmable ack delay
// answers the memory port; expected latencies and data are hand-computed.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [79:0] if_rdata;
  logic        if_done;
  logic        imem_error;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_done;
  logic        dmem_error;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_len;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [79:0] mem_rdata;
  logic        mem_ack;
  logic        owner;
  logic        busy;

  dmem_port_arbiter #(.MEM_SIZE(1024), .TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .imem_error(imem_error),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dmem_error(dmem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:1023];
  int         ack_delay  = 2;
  logic       ack_en     = 1'b1;
  int         wait_cnt   = 0;
  int         req_cycles = 0;

  // Memory model: acks on the ack_delay-th cycle of a held mem_req (0 = same cycle).
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (ack_en && wait_cnt == ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          for (int i = 0; i < 8; i++)
            if (mem_addr + 64'(i) < 64'd1024) mem[32'(mem_addr) + i] = mem_wdata[i*8 +: 8];
        end else begin
          for (int i = 0; i < 10; i++)
            mem_rdata[i*8 +: 8] = (mem_addr + 64'(i) < 64'd1024) ? mem[32'(mem_addr) + i] : 8'h00;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one data request from an IDLE cycle; lat counts cycles from request to dm_done.
  task automatic do_data(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         output int lat, output logic err);
    logic seen = 1'b0;
    lat = 0;
    err = 1'b0;
    dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (dm_done) begin
        seen = 1'b1;
        err  = dmem_error;
        break;
      end
    end
    check("dm_done_within_budget", seen, 1'b1);
    dm_req = 1'b0;
    step();
  endtask

  task automatic do_fetch(input logic [63:0] addr, output int lat, output logic err);
    logic seen = 1'b0;
    lat = 0;
    err = 1'b0;
    if_addr = addr; if_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (if_done) begin
        seen = 1'b1;
        err  = imem_error;
        break;
      end
    end
    check("if_done_within_budget", seen, 1'b1);
    if_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       err;
    logic       owners [6];
    logic [5:0] exp_owners;
    int         n_done;
    logic       stray;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16] = 8'h34; mem[17] = 8'h12;
    for (int i = 0; i < 8; i++) mem[64 + i] = 8'h88 - 8'(i * 8'h11);
    for (int i = 0; i < 10; i++) mem[1014 + i] = 8'(i + 1);
    mem_rdata = '0;
    mem_ack   = 1'b0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    step(); step();
    check("reset_busy",    busy,    1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_done",    {if_done, dm_done, imem_error, dmem_error}, 4'b0);
    check("reset_owner",   owner,   1'b0);
    check("reset_rdata",   {dm_rdata, if_rdata}, 144'h0);
    reset = 1'b0;
    step();

    // Read with ack two cycles after mem_req rises.
    ack_delay = 2;
    do_data(1'b0, 64'd16, 64'd0, lat, err);
    check("read_latency", lat, 4);
    check("read_err",     err, 1'b0);
    check("read_rdata",   dm_rdata, 64'h1234);

    // Continuous contention: expected owners at done D,D,D,D,F,D.
    ack_delay = 0;
    if_addr = 64'h20; dm_addr = 64'h40; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    n_done = 0;
    for (int i = 0; i < 60 && n_done < 6; i++) begin
      step();
      if (if_done || dm_done) begin
        owners[n_done] = dm_done;
        n_done++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    check("contention_done_count", n_done, 6);
    exp_owners = 6'b101111;
    for (int i = 0; i < 6; i++)
      if (i < n_done) check($sformatf("contention_owner_%0d", i), owners[i], exp_owners[i]);
    check("contention_dm_rdata", dm_rdata, 64'h1122334455667788);

    // Bounds.
    req_cycles = 0;
    do_data(1'b0, 64'd1017, 64'd0, lat, err);
    check("oob_dm_latency", lat, 1);
    check("oob_dm_err",     err, 1'b1);
    check("oob_dm_no_mem_req", req_cycles, 0);
    check("oob_dm_rdata_kept", dm_rdata, 64'h1122334455667788);
    do_data(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, lat, err);
    check("oob_max_addr_err", err, 1'b1);
    do_fetch(64'd1015, lat, err);
    check("oob_if_latency", lat, 1);
    check("oob_if_err",     err, 1'b1);
    check("oob_total_mem_req", req_cycles, 0);
    do_fetch(64'd1014, lat, err);
    check("edge_if_latency", lat, 2);
    check("edge_if_err",     err, 1'b0);
    check("edge_if_rdata",   if_rdata, 80'h0a090807060504030201);

    // Timeout: no ack ever.
    ack_en = 1'b0;
    req_cycles = 0;
    do_data(1'b0, 64'd16, 64'd0, lat, err);
    check("timeout_mem_req_cycles", req_cycles, 16);
    check("timeout_latency", lat, 17);
    check("timeout_err",     err, 1'b1);
    check("timeout_rdata_kept", dm_rdata, 64'h1122334455667788);

    // Reset during an in-flight write.
    dm_we = 1'b1; dm_addr = 64'd8; dm_wdata = 64'hDEAD_BEEF_CAFE_F00D; dm_req = 1'b1;
    step(); step(); step();
    check("pre_reset_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    step();
    check("midreset_ctrl", {mem_req, mem_we, busy, owner, if_done, dm_done, imem_error, dmem_error}, 8'h00);
    check("midreset_bus",  {mem_len, mem_addr, mem_wdata}, 132'h0);
    check("midreset_rdata", {dm_rdata, if_rdata}, 144'h0);
    reset = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      stray = stray | dm_done | if_done | mem_req;
    end
    check("post_reset_quiet", stray, 1'b0);
    ack_en = 1'b1;
    ack_delay = 2;
    do_data(1'b0, 64'd16, 64'd0, lat, err);
    check("post_reset_latency", lat, 4);
    check("post_reset_rdata",   dm_rdata, 64'h1234);

    // Write then fetch the same bytes.
    ack_delay = 1;
    do_data(1'b1, 64'd0, 64'h30F4_0A0B_0C0D_0E0F, lat, err);
    check("write_latency", lat, 3);
    check("write_err",     err, 1'b0);
    check("write_rdata_kept", dm_rdata, 64'h1234);
    do_fetch(64'd0, lat, err);
    check("fetch_after_write_err", err, 1'b0);
    check("fetch_after_write_rdata", if_rdata, 80'h0000_30F4_0A0B_0C0D_0E0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
